// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: holds PC and IF/ID on hazards forwarding
// cannot cover, squashes the fetch slot behind redirects, and drains the pipe on HALT.
module hazard_detection_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_branch,
    input  logic             ID_branch_taken,
    input  logic             ID_jump,
    input  logic             ID_halt,
    input  logic [4:0]       EX_rd,
    input  logic             EX_regF_wr,
    input  logic             EX_mem_rd,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_mem_rd,
    input  logic             resume,
    output logic             pc_wr,
    output logic             IF_ID_wr,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, br_ex, br_mem, stall, redirect;

    // $0 never carries a dependency, and an operand the instruction ignores cannot stall it.
    function automatic logic reg_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] rd);
        return used && (src != 5'd0) && (src == rd);
    endfunction

    assign rs_ex    = reg_match(ID_uses_rs, ID_rs, EX_rd);
    assign rt_ex    = reg_match(ID_uses_rt, ID_rt, EX_rd);
    assign rs_mem   = reg_match(ID_uses_rs, ID_rs, MEM_rd);
    assign rt_mem   = reg_match(ID_uses_rt, ID_rt, MEM_rd);

    assign load_use = EX_mem_rd && (rs_ex || rt_ex);
    assign br_ex    = ID_branch && EX_regF_wr && (rs_ex || rt_ex);
    assign br_mem   = ID_branch && MEM_mem_rd && (rs_mem || rt_mem);
    assign stall    = load_use || br_ex || br_mem;
    assign redirect = (ID_branch && ID_branch_taken) || ID_jump;

    always_comb begin
        // NOTE: every output and _d gets a default before any branch, so no path can infer a latch.
        state_d      = state_q;
        drain_d      = drain_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_wr        = 1'b0;
        IF_ID_wr     = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b1;

        unique case (state_q)
            RUN: begin
                if (stall) begin
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end else if (ID_halt) begin
                    // HALT moves on to EX while fetch is frozen and the slot behind it squashed.
                    IF_ID_wr     = 1'b1;
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b0;
                    state_d      = DRAIN;
                    drain_d      = DW'(DRAIN_CYCLES - 1);
                end else begin
                    pc_wr        = 1'b1;
                    IF_ID_wr     = 1'b1;
                    ID_EX_bubble = 1'b0;
                    if (redirect) begin
                        IF_ID_flush = 1'b1;
                        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = HALTED;
                else               drain_d = drain_q - DW'(1);
            end
            HALTED: begin
                if (resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            pc_wr        = 1'b0;
            IF_ID_wr     = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            state_d      = RUN;
            drain_d      = '0;
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
        end

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments; reset is already folded into the _d values.
        state_q     <= state_d;
        drain_q     <= drain_d;
        halted_q    <= halted_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign halted    = halted_q && !rst;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a vector table for the combinational decode in RUN,
// then hand-written sequences for load->branch, halt/drain/resume, mid-drain reset and saturation.
module tb_hazard_detection_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ID_rs, ID_rt, EX_rd, MEM_rd;
    logic             ID_uses_rs, ID_uses_rt, ID_branch, ID_branch_taken, ID_jump, ID_halt;
    logic             EX_regF_wr, EX_mem_rd, MEM_mem_rd, resume;
    logic             pc_wr, IF_ID_wr, IF_ID_flush, ID_EX_bubble, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_detection_unit #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_branch(ID_branch), .ID_branch_taken(ID_branch_taken), .ID_jump(ID_jump),
        .ID_halt(ID_halt), .EX_rd(EX_rd), .EX_regF_wr(EX_regF_wr), .EX_mem_rd(EX_mem_rd),
        .MEM_rd(MEM_rd), .MEM_mem_rd(MEM_mem_rd), .resume(resume),
        .pc_wr(pc_wr), .IF_ID_wr(IF_ID_wr), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected control word is {pc_wr, IF_ID_wr, IF_ID_flush, ID_EX_bubble}.
    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, jp, ht;
        logic [4:0] exrd;
        logic       exwr, exld;
        logic [4:0] memrd;
        logic       memld;
        logic [3:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic br,
                                input logic tk, input logic jp, input logic ht,
                                input logic [4:0] exrd, input logic exwr, input logic exld,
                                input logic [4:0] memrd, input logic memld,
                                input logic [3:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.br = br; v.tk = tk; v.jp = jp; v.ht = ht;
        v.exrd = exrd; v.exwr = exwr; v.exld = exld;
        v.memrd = memrd; v.memld = memld; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ctl();
        return {pc_wr, IF_ID_wr, IF_ID_flush, ID_EX_bubble};
    endfunction

    task automatic idle();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        ID_branch = 1'b0; ID_branch_taken = 1'b0; ID_jump = 1'b0; ID_halt = 1'b0;
        EX_rd = 5'd0; EX_regF_wr = 1'b0; EX_mem_rd = 1'b0;
        MEM_rd = 5'd0; MEM_mem_rd = 1'b0; resume = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        ID_rs = v.rs; ID_rt = v.rt; ID_uses_rs = v.urs; ID_uses_rt = v.urt;
        ID_branch = v.br; ID_branch_taken = v.tk; ID_jump = v.jp; ID_halt = v.ht;
        EX_rd = v.exrd; EX_regF_wr = v.exwr; EX_mem_rd = v.exld;
        MEM_rd = v.memrd; MEM_mem_rd = v.memld; resume = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic load_use_inputs();
        idle();
        ID_rs = 5'd2; ID_uses_rs = 1'b1;
        EX_rd = 5'd2; EX_regF_wr = 1'b1; EX_mem_rd = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk("normal",          5'd1,  5'd2, 1,1, 0,0,0,0, 5'd9, 1,0, 5'd10, 0, 4'b1100));
        vecs.push_back(mk("load_use_rs",     5'd2,  5'd6, 1,1, 0,0,0,0, 5'd2, 1,1, 5'd0,  0, 4'b0001));
        vecs.push_back(mk("load_use_rt",     5'd6,  5'd7, 1,1, 0,0,0,0, 5'd7, 1,1, 5'd0,  0, 4'b0001));
        vecs.push_back(mk("ld_rd_zero",      5'd0,  5'd0, 1,1, 0,0,0,0, 5'd0, 1,1, 5'd0,  0, 4'b1100));
        vecs.push_back(mk("ld_rt_unused",    5'd1,  5'd5, 1,0, 0,0,0,0, 5'd5, 1,1, 5'd0,  0, 4'b1100));
        vecs.push_back(mk("br_ex",           5'd3,  5'd8, 1,1, 1,0,0,0, 5'd3, 1,0, 5'd0,  0, 4'b0001));
        vecs.push_back(mk("br_mem",          5'd9,  5'd4, 1,1, 1,1,0,0, 5'd0, 0,0, 5'd4,  1, 4'b0001));
        vecs.push_back(mk("mem_ld_no_br",    5'd4,  5'd1, 1,1, 0,0,0,0, 5'd0, 0,0, 5'd4,  1, 4'b1100));
        vecs.push_back(mk("alu_no_br",       5'd3,  5'd1, 1,1, 0,0,0,0, 5'd3, 1,0, 5'd0,  0, 4'b1100));
        vecs.push_back(mk("br_taken",        5'd3,  5'd4, 1,1, 1,1,0,0, 5'd0, 0,0, 5'd0,  0, 4'b1110));
        vecs.push_back(mk("br_not_taken",    5'd3,  5'd4, 1,1, 1,0,0,0, 5'd0, 0,0, 5'd0,  0, 4'b1100));
        vecs.push_back(mk("jump",            5'd31, 5'd0, 1,0, 0,0,1,0, 5'd5, 1,0, 5'd6,  1, 4'b1110));
        vecs.push_back(mk("stall_vs_taken",  5'd3,  5'd4, 1,1, 1,1,0,0, 5'd3, 1,0, 5'd0,  0, 4'b0001));
        vecs.push_back(mk("stall_vs_halt",   5'd2,  5'd0, 1,0, 0,0,0,1, 5'd2, 1,1, 5'd0,  0, 4'b0001));
        vecs.push_back(mk("taken_no_branch", 5'd3,  5'd4, 1,1, 0,1,0,0, 5'd0, 0,0, 5'd0,  0, 4'b1100));
        vecs.push_back(mk("br_mem_alu",      5'd4,  5'd1, 1,1, 1,0,0,0, 5'd0, 0,0, 5'd4,  0, 4'b1100));

        // Reset values while rst is held, and state after release.
        idle();
        rst = 1'b1;
        #1;
        check("rst_ctl", 32'(ctl()), 32'h3);
        check("rst_halted", 32'(halted), 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("post_rst_ctl", 32'(ctl()), 32'hC);
        check("post_rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("post_rst_flush_cnt", 32'(flush_cnt), 32'h0);

        // Table: one vector per RUN cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #1;
            check(vecs[i].name, 32'(ctl()), 32'(vecs[i].exp));
            next_cycle();
        end
        idle();
        #1;
        check("table_stall_cnt", 32'(stall_cnt), 32'd6);
        check("table_flush_cnt", 32'(flush_cnt), 32'd2);
        check("table_halted", 32'(halted), 32'h0);

        // Load-use: exactly one stall cycle.
        do_reset();
        load_use_inputs();
        #1;
        check("lu_stall", 32'(ctl()), 32'h1);
        next_cycle();
        EX_mem_rd = 1'b0; EX_regF_wr = 1'b0; EX_rd = 5'd0;
        MEM_rd = 5'd2; MEM_mem_rd = 1'b1;
        #1;
        check("lu_release", 32'(ctl()), 32'hC);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load feeding a taken beq: br_ex, then br_mem, then the redirect flush.
        do_reset();
        ID_rs = 5'd3; ID_rt = 5'd0; ID_uses_rs = 1'b1; ID_uses_rt = 1'b1;
        ID_branch = 1'b1; ID_branch_taken = 1'b1;
        EX_rd = 5'd3; EX_regF_wr = 1'b1; EX_mem_rd = 1'b1;
        #1;
        check("ldbr_cyc1", 32'(ctl()), 32'h1);
        next_cycle();
        EX_rd = 5'd0; EX_regF_wr = 1'b0; EX_mem_rd = 1'b0;
        MEM_rd = 5'd3; MEM_mem_rd = 1'b1;
        #1;
        check("ldbr_cyc2", 32'(ctl()), 32'h1);
        next_cycle();
        MEM_rd = 5'd0; MEM_mem_rd = 1'b0;
        #1;
        check("ldbr_flush", 32'(ctl()), 32'hE);
        next_cycle();
        idle();
        #1;
        check("ldbr_after", 32'(ctl()), 32'hC);
        check("ldbr_stall_cnt", 32'(stall_cnt), 32'd2);
        check("ldbr_flush_cnt", 32'(flush_cnt), 32'd1);

        // Stall beats halt, then halt enters on the following cycle.
        do_reset();
        load_use_inputs();
        ID_halt = 1'b1;
        #1;
        check("sh_stall", 32'(ctl()), 32'h1);
        next_cycle();
        idle();
        ID_halt = 1'b1;
        #1;
        check("sh_halt_entry", 32'(ctl()), 32'h6);
        next_cycle();
        idle();
        #1;
        check("sh_drain", 32'(ctl()), 32'h1);

        // Halt/drain/halted/resume; hazards and resume outside HALTED are ignored.
        do_reset();
        ID_halt = 1'b1;
        resume = 1'b1;
        #1;
        check("halt_entry_ctl", 32'(ctl()), 32'h6);
        check("halt_entry_halted", 32'(halted), 32'h0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            idle();
            ID_halt = 1'b1; ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_jump = 1'b1;
            ID_rs = 5'd2; ID_uses_rs = 1'b1; EX_rd = 5'd2; EX_mem_rd = 1'b1;
            resume = 1'b1;
            #1;
            check($sformatf("drain%0d_ctl", k), 32'(ctl()), 32'h1);
            check($sformatf("drain%0d_halted", k), 32'(halted), 32'h0);
            next_cycle();
        end
        idle();
        #1;
        check("halted_ctl", 32'(ctl()), 32'h1);
        check("halted_flag", 32'(halted), 32'h1);
        next_cycle();
        ID_jump = 1'b1;
        #1;
        check("halted_jump_ignored", 32'(ctl()), 32'h1);
        idle();
        resume = 1'b1;
        #1;
        check("resume_cycle_halted", 32'(halted), 32'h1);
        check("resume_cycle_ctl", 32'(ctl()), 32'h1);
        next_cycle();
        idle();
        #1;
        check("after_resume_ctl", 32'(ctl()), 32'hC);
        check("after_resume_halted", 32'(halted), 32'h0);
        check("halt_flush_not_counted", 32'(flush_cnt), 32'd0);
        check("drain_stall_not_counted", 32'(stall_cnt), 32'd0);

        // Reset in the second DRAIN cycle clears state and counters.
        do_reset();
        load_use_inputs();
        next_cycle();
        idle();
        ID_jump = 1'b1;
        next_cycle();
        idle();
        ID_halt = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        rst = 1'b1;
        #1;
        check("mid_drain_rst_ctl", 32'(ctl()), 32'h3);
        check("mid_drain_rst_halted", 32'(halted), 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("mid_drain_post_ctl", 32'(ctl()), 32'hC);
        check("mid_drain_stall_cnt", 32'(stall_cnt), 32'd0);
        check("mid_drain_flush_cnt", 32'(flush_cnt), 32'd0);
        repeat (4) next_cycle();
        check("mid_drain_stays_run", 32'(halted), 32'h0);
        check("mid_drain_run_ctl", 32'(ctl()), 32'hC);

        // Saturation: 20 stall cycles on a 4-bit counter.
        do_reset();
        load_use_inputs();
        repeat (20) next_cycle();
        check("stall_cnt_saturate", 32'(stall_cnt), 32'd15);
        idle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Stall/flush controller for the 5-stage MIPS pipeline; the counterpart of the EX-stage forwarding unit. Forwarding resolves the hazards it can; this block handles the rest by holding PC and IF/ID. It also inserts ID/EX bubbles, squashes the fetch slot behind taken branches and jumps, and drains the pipeline on HALT. It sits beside the ID stage and drives the write enables of the PC and IF/ID registers. Registered state covers the halt FSM and saturating performance counters.

## Interface
- DRAIN_CYCLES, 3: cycles spent in DRAIN after HALT leaves ID (EX, MEM, WB retire).
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_uses_rs, ID_uses_rt  in  1 each  instruction in ID actually reads rs / rt.
- ID_branch  in  1  conditional branch in ID (compared in ID).
- ID_branch_taken  in  1  ID comparator result, valid with ID_branch.
- ID_jump  in  1  J/JAL/JR in ID.
- ID_halt  in  1  HALT opcode in ID.
- EX_rd  in  5  destination register in EX.
- EX_regF_wr, EX_mem_rd  in  1 each  EX writes the register file / EX is a load.
- MEM_rd  in  5  destination register in MEM.
- MEM_mem_rd  in  1  MEM is a load.
- resume  in  1  debug resume request, honoured only in HALTED.
- pc_wr  out  1  PC write enable.
- IF_ID_wr  out  1  IF/ID write enable.
- IF_ID_flush  out  1  IF/ID loads a NOP at the next edge.
- ID_EX_bubble  out  1  ID/EX control fields are zeroed at the next edge.
- halted  out  1  pipeline drained and frozen.
- stall_cnt, flush_cnt  out  CNT_W each  saturating stall-cycle and flush-cycle counts.

## Operation
- A register matches when it is used by the instruction in ID, is non-zero, and equals the producer's rd.
- load_use = EX_mem_rd and (EX_rd matches rs or rt).
- br_ex = ID_branch and EX_regF_wr and (EX_rd matches rs or rt).
- br_mem = ID_branch and MEM_mem_rd and (MEM_rd matches rs or rt).
- stall = load_use or br_ex or br_mem.
- A load feeding a branch therefore stalls 2 cycles: first via br_ex, then via br_mem. Both are re-evaluated each cycle, so there is no stall counter.
- FSM states are RUN, DRAIN, HALTED; reset state is RUN.
- Priority within RUN: stall > halt entry > taken/jump flush > normal.
- RUN, stall: pc_wr=0, IF_ID_wr=0, ID_EX_bubble=1, IF_ID_flush=0.
- RUN, ID_halt with no stall: pc_wr=0, IF_ID_wr=1, IF_ID_flush=1, ID_EX_bubble=0. HALT advances to EX; next state DRAIN; drain counter loads DRAIN_CYCLES-1.
- RUN, (ID_branch and ID_branch_taken) or ID_jump, with no stall and no halt: pc_wr=1, IF_ID_wr=1, IF_ID_flush=1, ID_EX_bubble=0.
- RUN, otherwise: pc_wr=1, IF_ID_wr=1, IF_ID_flush=0, ID_EX_bubble=0.
- DRAIN: pc_wr=0, IF_ID_wr=0, ID_EX_bubble=1, IF_ID_flush=0. The counter decrements each cycle; the cycle with counter 0 transitions to HALTED.
- HALTED: same outputs as DRAIN plus halted=1. resume=1 gives next state RUN. PC still holds the address after HALT, so execution continues from there.
- Hazard inputs are ignored in DRAIN and HALTED. resume is ignored outside HALTED.
- stall_cnt increments in every RUN cycle with stall=1.
- flush_cnt increments in every RUN cycle in which the taken/jump flush row applies. The halt-entry flush is not counted.
- Both counters saturate at 2^CNT_W-1 and hold there; they never wrap.
- While rst=1: pc_wr=0, IF_ID_wr=0, IF_ID_flush=1, ID_EX_bubble=1, halted=0. At the edge: state RUN, counters 0, drain counter 0. This applies at any point, including mid-DRAIN and in HALTED.

## Timing
- pc_wr, IF_ID_wr, IF_ID_flush and ID_EX_bubble are combinational from the inputs and current state, and are valid in the same cycle.
- halted, stall_cnt and flush_cnt are registered; they update on the edge ending the cycle that caused the change.
- Halt entry in cycle T gives DRAIN in cycles T+1..T+DRAIN_CYCLES and halted=1 from T+DRAIN_CYCLES+1.
- resume in HALTED cycle H: RUN outputs in H+1, and halted falls at the H edge.
- Simultaneous stall and ID_halt: stall wins, and halt is re-examined the next cycle.
- Simultaneous stall and taken branch: stall wins, no flush, flush_cnt unchanged.

## Test plan
- Load-use: lw $2 in EX (EX_mem_rd=1, EX_rd=2) and add reading $2 in ID -> exactly 1 cycle of pc_wr=0/IF_ID_wr=0/ID_EX_bubble=1, then normal; stall_cnt 0->1.
- Load feeding beq: lw $3 then beq $3 -> 2 stall cycles (br_ex then br_mem); beq taken -> one IF_ID_flush cycle; stall_cnt=2, flush_cnt=1.
- $0 and unused-operand filtering: EX_rd=0 load, and a load to $5 with ID_uses_rt=0 and ID_rt=5 -> no stall.
- Halt with DRAIN_CYCLES=3: ID_halt in cycle 10 -> pc_wr=0 and IF_ID_flush=1 in 10, DRAIN in 11-13, halted=1 from 14; resume in 20 -> pc_wr=1 in 21.
- Reset in the 2nd DRAIN cycle -> outputs take reset values while rst=1; state RUN, halted=0, counters 0 after release.
- Saturation with CNT_W=4: 20 consecutive stall cycles -> stall_cnt holds 15.
